// File: rtl/ct_pmp_pkg.sv
// Shared encodings and the response record for the PMP permission-check stage.
package ct_pmp_pkg;

    localparam int PMP_ENTRY_NUM = 8;
    localparam int PMP_ENT_W     = 3;
    localparam int PMP_PA_W      = 28;

    typedef enum logic [1:0] {
        ACC_LOAD  = 2'b00,
        ACC_STORE = 2'b01,
        ACC_FETCH = 2'b10,
        ACC_RSV   = 2'b11
    } pmp_acc_e;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } pmp_priv_e;

    typedef struct packed {
        logic                 deny;
        logic                 hit;
        logic [PMP_ENT_W-1:0] entry;
    } pmp_rsp_t;

endpackage

// File: rtl/ct_pmp_prio_sel.sv
// Combinational winner selection (lowest hitting entry) and R/W/X/L permission decision.
module ct_pmp_prio_sel
    import ct_pmp_pkg::*;
#(
    parameter int ENTRY_NUM = PMP_ENTRY_NUM
) (
    input  logic [ENTRY_NUM-1:0] hit_vec,
    input  logic [ENTRY_NUM-1:0] cfg_r,
    input  logic [ENTRY_NUM-1:0] cfg_w,
    input  logic [ENTRY_NUM-1:0] cfg_x,
    input  logic [ENTRY_NUM-1:0] cfg_l,
    input  logic [1:0]           acc_type,
    input  logic [1:0]           priv,
    output pmp_rsp_t             rsp
);

    logic [PMP_ENT_W-1:0] win_idx;
    logic                 win_hit;
    logic                 perm_bit;
    logic                 is_m;
    logic                 allow;

    // Scanning downward lets the lowest-numbered hit overwrite any higher one.
    always_comb begin
        win_idx = '0;
        win_hit = 1'b0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_idx = PMP_ENT_W'(i);
                win_hit = 1'b1;
            end
        end
    end

    always_comb begin
        perm_bit = 1'b0;
        case (acc_type)
            ACC_LOAD:  perm_bit = cfg_r[win_idx];
            ACC_STORE: perm_bit = cfg_w[win_idx];
            ACC_FETCH: perm_bit = cfg_x[win_idx];
            default:   perm_bit = 1'b0;
        endcase
    end

    // Reserved privilege 2'b10 falls through as non-M, i.e. behaves as U.
    assign is_m = (priv == PRIV_M);

    always_comb begin
        allow = 1'b0;
        if (acc_type == ACC_RSV) begin
            allow = 1'b0;
        end else if (win_hit) begin
            allow = (is_m && !cfg_l[win_idx]) || perm_bit;
        end else begin
            allow = is_m;
        end
    end

    assign rsp.deny  = !allow;
    assign rsp.hit   = win_hit;
    assign rsp.entry = win_idx;

endmodule

// File: rtl/ct_pmp_perm_chk.sv
// PMP permission response stage: OUT register plus one-entry skid, deny counter, sticky fault capture.
module ct_pmp_perm_chk
    import ct_pmp_pkg::*;
#(
    parameter int ENTRY_NUM = PMP_ENTRY_NUM,
    parameter int PA_W      = PMP_PA_W,
    parameter int ENT_W     = PMP_ENT_W
) (
    input  logic                 cpuclk,
    input  logic                 cpurst,
    input  logic                 mmu_pmp_req_vld,
    output logic                 pmp_mmu_req_rdy,
    input  logic [PA_W-1:0]      mmu_pmp_pa,
    input  logic [1:0]           mmu_pmp_acc_type,
    input  logic [1:0]           mmu_pmp_priv,
    input  logic [ENTRY_NUM-1:0] pmp_hit_vec,
    input  logic [ENTRY_NUM-1:0] pmpcfg_r,
    input  logic [ENTRY_NUM-1:0] pmpcfg_w,
    input  logic [ENTRY_NUM-1:0] pmpcfg_x,
    input  logic [ENTRY_NUM-1:0] pmpcfg_l,
    input  logic                 cp0_pmp_flush,
    input  logic                 cp0_pmp_fault_clr,
    output logic                 pmp_mmu_rsp_vld,
    input  logic                 mmu_pmp_rsp_rdy,
    output logic                 pmp_mmu_rsp_deny,
    output logic                 pmp_mmu_rsp_hit,
    output logic [ENT_W-1:0]     pmp_mmu_rsp_entry,
    output logic [15:0]          pmp_cp0_deny_cnt,
    output logic                 pmp_cp0_fault_vld,
    output logic [PA_W-1:0]      pmp_cp0_fault_pa
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    pmp_rsp_t        new_rsp_p0;
    logic            out_vld_p1;
    logic            skid_vld_p1;
    pmp_rsp_t        out_rsp_p1;
    pmp_rsp_t        skid_rsp_p1;
    logic [PA_W-1:0] out_pa_p1;
    logic [PA_W-1:0] skid_pa_p1;
    logic            req_fire;
    logic            rsp_fire;
    logic            out_free;

    ct_pmp_prio_sel #(
        .ENTRY_NUM (ENTRY_NUM)
    ) u_prio_sel (
        .hit_vec  (pmp_hit_vec),
        .cfg_r    (pmpcfg_r),
        .cfg_w    (pmpcfg_w),
        .cfg_x    (pmpcfg_x),
        .cfg_l    (pmpcfg_l),
        .acc_type (mmu_pmp_acc_type),
        .priv     (mmu_pmp_priv),
        .rsp      (new_rsp_p0)
    );

    assign pmp_mmu_req_rdy = !skid_vld_p1 && !cp0_pmp_flush;
    assign req_fire        = mmu_pmp_req_vld && pmp_mmu_req_rdy;
    assign rsp_fire        = out_vld_p1 && mmu_pmp_rsp_rdy;
    assign out_free        = !out_vld_p1 || mmu_pmp_rsp_rdy;

    // p0 -> p1: slot occupancy. A request can never fire while SKID is full,
    // so draining SKID into OUT and accepting a new request are exclusive.
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (cp0_pmp_flush) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (out_free) begin
            out_vld_p1  <= skid_vld_p1 || req_fire;
            skid_vld_p1 <= 1'b0;
        end else if (req_fire) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            out_rsp_p1 <= '0;
        end else if (!cp0_pmp_flush && out_free) begin
            if (skid_vld_p1) begin
                out_rsp_p1 <= skid_rsp_p1;
            end else if (req_fire) begin
                out_rsp_p1 <= new_rsp_p0;
            end
        end
    end

    always_ff @(posedge cpuclk) begin
        if (out_free) begin
            if (skid_vld_p1) begin
                out_pa_p1 <= skid_pa_p1;
            end else if (req_fire) begin
                out_pa_p1 <= mmu_pmp_pa;
            end
        end
        if (!out_free && req_fire) begin
            skid_rsp_p1 <= new_rsp_p0;
            skid_pa_p1  <= mmu_pmp_pa;
        end
    end

    // p1 -> p2: CP0 statistics, taken from completed handshakes only.
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            pmp_cp0_deny_cnt  <= 16'd0;
            pmp_cp0_fault_vld <= 1'b0;
            pmp_cp0_fault_pa  <= '0;
        end else begin
            if (rsp_fire && out_rsp_p1.deny) begin
                pmp_cp0_deny_cnt <= sat_inc(pmp_cp0_deny_cnt);
            end
            // A denial coinciding with a clear re-arms and captures in one step.
            if (rsp_fire && out_rsp_p1.deny && (!pmp_cp0_fault_vld || cp0_pmp_fault_clr)) begin
                pmp_cp0_fault_vld <= 1'b1;
                pmp_cp0_fault_pa  <= out_pa_p1;
            end else if (cp0_pmp_fault_clr) begin
                pmp_cp0_fault_vld <= 1'b0;
            end
        end
    end

    assign pmp_mmu_rsp_vld   = out_vld_p1;
    assign pmp_mmu_rsp_deny  = out_rsp_p1.deny;
    assign pmp_mmu_rsp_hit   = out_rsp_p1.hit;
    assign pmp_mmu_rsp_entry = ENT_W'(out_rsp_p1.entry);

endmodule
